e203_exu_alu_rglr_buf: RTL and testbench
========================================

Name: e203_exu_alu_rglr_buf

Overview:
- Regular-ALU issue/commit stage with a parametrised result buffer between the shared ALU datapath and the write-back/commit interface.
- Decodes operand select and opcode bits, drives the shared ALU datapath in the accept cycle, and captures the result and commit flags into a DEPTH-entry FIFO.
- Write-back is therefore registered (1-cycle minimum latency) and decoupled from upstream stalls.
- Adds flush and an occupancy output, so the block can sit in a deeper EXU pipeline.

Parameters:
XLEN, 32, data width of operands, immediate and result
PC_SIZE, 32, PC width; must be <= XLEN, zero-extended to XLEN when selected as op1
DEPTH, 2, result FIFO entries; legal range 1..8
CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > DEPTH

Ports:
- Clock, reset:
  - clk  in  1  clock; all state on rising edge
  - rst_n  in  1  asynchronous active-low reset
- Issue interface:
  - alu_i_valid  in  1  issue valid
  - alu_i_ready  out  1  issue ready
  - alu_i_rs1  in  XLEN  source operand 1
  - alu_i_rs2  in  XLEN  source operand 2
  - alu_i_imm  in  XLEN  immediate
  - alu_i_pc  in  PC_SIZE  instruction PC
  - alu_i_info  in  E203_DECINFO_ALU_WIDTH  decode info, standard E203_DECINFO_ALU_* bit positions
  - alu_i_flush  in  1  synchronous flush of all buffered results
- Write-back/commit interface:
  - alu_o_valid  out  1  write-back valid (FIFO not empty)
  - alu_o_ready  in  1  write-back ready
  - alu_o_wbck_wdat  out  XLEN  result at FIFO head
  - alu_o_wbck_err  out  1  head entry is ecall|ebreak|wfi
  - alu_o_cmt_ecall  out  1  head ecall flag
  - alu_o_cmt_ebreak  out  1  head ebreak flag
  - alu_o_cmt_wfi  out  1  head wfi flag
  - alu_o_pend_cnt  out  CNT_W  current FIFO occupancy
- Shared ALU datapath:
  - alu_req_alu_add/sub/xor/sll/srl/sra/or/and/slt/sltu/lui  out  1 each  opcode selects
  - alu_req_alu_op1  out  XLEN  op1
  - alu_req_alu_op2  out  XLEN  op2
  - alu_req_alu_res  in  XLEN  combinational datapath result, same cycle

Behaviour:
- Reset (async, rst_n=0):
  - count, rd_ptr and wr_ptr = 0; all entries (data and flags) = 0.
  - Outputs: alu_o_valid=0, alu_o_pend_cnt=0, wdat/err/ecall/ebreak/wfi=0.
  - Reset mid-operation discards all entries immediately.
- Datapath drive (combinational, independent of valid):
  - op1 = OP1PC ? zero-extended alu_i_pc : alu_i_rs1.
  - op2 = OP2IMM ? alu_i_imm : alu_i_rs2.
  - alu_req_alu_add = ADD & ~NOP; all other selects map directly from their info bits.
- Handshakes:
  - push = alu_i_valid & alu_i_ready; pop = alu_o_valid & alu_o_ready.
  - alu_i_ready = ~alu_i_flush & ((count < DEPTH) | alu_o_ready).
  - When full with simultaneous pop, the push is accepted (same-cycle replace).
  - alu_o_valid = (count != 0), registered; it never depends combinationally on alu_i_valid, so there is no input-to-output bypass.
- Push: entry[wr_ptr] <= {alu_req_alu_res, ECAL, EBRK, WFI}; wr_ptr increments, wrapping from DEPTH-1 to 0.
- Pop: rd_ptr increments with the same wrap rule. Head outputs always reflect entry[rd_ptr].
- alu_o_wbck_err = head ecall | ebreak | wfi.
- Count:
  - push only: +1; pop only: -1; both or neither: unchanged.
  - Never exceeds DEPTH; never underflows, since pop requires count != 0.
- Flush:
  - count, rd_ptr and wr_ptr <= 0 on the next edge; entry contents are left stale but masked because alu_o_valid=0.
  - Flush overrides push and pop in the same cycle: alu_i_ready=0; a pop handshake in the flush cycle is still legal downstream, and the entry is dropped anyway.
- Latency: accept in cycle N -> alu_o_valid and head data in cycle N+1 when the FIFO was empty.
- Throughput: 1 instruction per cycle sustained while alu_o_ready=1.
- alu_o_pend_cnt = count, registered.

Test Plan:
- Reset, then ADDI with rs1=5, imm=3, OP2IMM=1, datapath returns 8 -> cycle+1 valid=1, wdat=8, err=0, pend_cnt=1; pop -> pend_cnt=0.
- NOP (ADD=1, NOP=1) -> alu_req_alu_add=0; entry still written; AUIPC with OP1PC=1, pc=0x80000000 -> op1=0x80000000.
- DEPTH=2, alu_o_ready=0, issue 3 back-to-back -> first two accepted, alu_i_ready=0 on the third, pend_cnt=2; raise alu_o_ready -> results pop in order, third accepted during the full+pop cycle.
- ECALL issued (ECAL=1) -> head ecall=1, err=1; next entry EBRK -> ebreak=1, err=1; WFI -> wfi=1, err=1.
- Pointer wrap: 7 push/pop pairs with DEPTH=2, results 1..7 -> output order 1..7, no loss or duplication.
- With 2 entries held, assert alu_i_flush together with alu_i_valid -> alu_i_ready=0, next cycle valid=0, pend_cnt=0; rst_n pulsed mid-stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/e203_exu_alu_rglr_buf.sv
// e203_exu_alu_rglr_buf: regular-ALU issue stage driving the shared datapath,
// with results and commit flags held in a DEPTH-entry FIFO before write-back.
module e203_exu_alu_rglr_buf #(
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 4,
    parameter int INFO_W  = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_i_valid,
    output logic               alu_i_ready,
    input  logic [XLEN-1:0]    alu_i_rs1,
    input  logic [XLEN-1:0]    alu_i_rs2,
    input  logic [XLEN-1:0]    alu_i_imm,
    input  logic [PC_SIZE-1:0] alu_i_pc,
    input  logic [INFO_W-1:0]  alu_i_info,
    input  logic               alu_i_flush,
    output logic               alu_o_valid,
    input  logic               alu_o_ready,
    output logic [XLEN-1:0]    alu_o_wbck_wdat,
    output logic               alu_o_wbck_err,
    output logic               alu_o_cmt_ecall,
    output logic               alu_o_cmt_ebreak,
    output logic               alu_o_cmt_wfi,
    output logic [CNT_W-1:0]   alu_o_pend_cnt,
    output logic               alu_req_alu_add,
    output logic               alu_req_alu_sub,
    output logic               alu_req_alu_xor,
    output logic               alu_req_alu_sll,
    output logic               alu_req_alu_srl,
    output logic               alu_req_alu_sra,
    output logic               alu_req_alu_or,
    output logic               alu_req_alu_and,
    output logic               alu_req_alu_slt,
    output logic               alu_req_alu_sltu,
    output logic               alu_req_alu_lui,
    output logic [XLEN-1:0]    alu_req_alu_op1,
    output logic [XLEN-1:0]    alu_req_alu_op2,
    input  logic [XLEN-1:0]    alu_req_alu_res
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int ADD = 4, SUB = 5, XOR = 6, SLL = 7, SRL = 8, SRA = 9, OR = 10, AND = 11;
    localparam int SLT = 12, SLTU = 13, LUI = 14, OP2IMM = 15, OP1PC = 16, NOP = 17;
    localparam int ECAL = 18, EBRK = 19, WFI = 20;

    logic [XLEN-1:0]  dat_q [DEPTH];
    logic [2:0]       flg_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    logic             unused_info;

    assign unused_info      = ^alu_i_info[3:0];
    assign alu_req_alu_op1  = alu_i_info[OP1PC] ? XLEN'(alu_i_pc) : alu_i_rs1;
    assign alu_req_alu_op2  = alu_i_info[OP2IMM] ? alu_i_imm : alu_i_rs2;
    assign alu_req_alu_add  = alu_i_info[ADD] & ~alu_i_info[NOP];
    assign alu_req_alu_sub  = alu_i_info[SUB];
    assign alu_req_alu_xor  = alu_i_info[XOR];
    assign alu_req_alu_sll  = alu_i_info[SLL];
    assign alu_req_alu_srl  = alu_i_info[SRL];
    assign alu_req_alu_sra  = alu_i_info[SRA];
    assign alu_req_alu_or   = alu_i_info[OR];
    assign alu_req_alu_and  = alu_i_info[AND];
    assign alu_req_alu_slt  = alu_i_info[SLT];
    assign alu_req_alu_sltu = alu_i_info[SLTU];
    assign alu_req_alu_lui  = alu_i_info[LUI];

    // a full FIFO still accepts when the head leaves in the same cycle
    assign alu_i_ready = ~alu_i_flush & ((cnt_q < CNT_W'(DEPTH)) | alu_o_ready);
    assign alu_o_valid = cnt_q != '0;
    assign push        = alu_i_valid & alu_i_ready;
    assign pop         = alu_o_valid & alu_o_ready;

    assign alu_o_wbck_wdat = dat_q[rd_q];
    assign {alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi} = flg_q[rd_q];
    assign alu_o_wbck_err  = |flg_q[rd_q];
    assign alu_o_pend_cnt  = cnt_q;

    always_comb begin
        rd_d  = alu_i_flush ? '0 : pop ? (rd_q == PTR_W'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        wr_d  = alu_i_flush ? '0 : push ? (wr_q == PTR_W'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        cnt_d = alu_i_flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push) begin
                dat_q[wr_q] <= alu_req_alu_res;
                flg_q[wr_q] <= {alu_i_info[ECAL], alu_i_info[EBRK], alu_i_info[WFI]};
            end
        end
    end
endmodule

// File: tb/tb_e203_exu_alu_rglr_buf.sv
// tb_e203_exu_alu_rglr_buf: scoreboard bench; driver pushes model results, negedge monitor pops and compares.
module tb_e203_exu_alu_rglr_buf;
    localparam int DEPTH = 2;
    typedef logic [34:0] ent_t;

    logic        clk = 0, rst_n = 0;
    logic        alu_i_valid = 0, alu_i_ready, alu_i_flush = 0;
    logic [31:0] alu_i_rs1 = 0, alu_i_rs2 = 0, alu_i_imm = 0, alu_i_pc = 0;
    logic [20:0] alu_i_info = 0;
    logic        alu_o_valid, alu_o_ready = 0;
    logic [31:0] alu_o_wbck_wdat;
    logic        alu_o_wbck_err, alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi;
    logic [3:0]  alu_o_pend_cnt;
    logic        s_add, s_sub, s_xor, s_sll, s_srl, s_sra, s_or, s_and, s_slt, s_sltu, s_lui;
    logic [31:0] op1, op2, res;

    int   checks = 0, failures = 0;
    bit   mon_en = 0;
    ent_t q[$];

    e203_exu_alu_rglr_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready),
        .alu_i_rs1(alu_i_rs1), .alu_i_rs2(alu_i_rs2), .alu_i_imm(alu_i_imm),
        .alu_i_pc(alu_i_pc), .alu_i_info(alu_i_info), .alu_i_flush(alu_i_flush),
        .alu_o_valid(alu_o_valid), .alu_o_ready(alu_o_ready),
        .alu_o_wbck_wdat(alu_o_wbck_wdat), .alu_o_wbck_err(alu_o_wbck_err),
        .alu_o_cmt_ecall(alu_o_cmt_ecall), .alu_o_cmt_ebreak(alu_o_cmt_ebreak),
        .alu_o_cmt_wfi(alu_o_cmt_wfi), .alu_o_pend_cnt(alu_o_pend_cnt),
        .alu_req_alu_add(s_add), .alu_req_alu_sub(s_sub), .alu_req_alu_xor(s_xor),
        .alu_req_alu_sll(s_sll), .alu_req_alu_srl(s_srl), .alu_req_alu_sra(s_sra),
        .alu_req_alu_or(s_or), .alu_req_alu_and(s_and), .alu_req_alu_slt(s_slt),
        .alu_req_alu_sltu(s_sltu), .alu_req_alu_lui(s_lui),
        .alu_req_alu_op1(op1), .alu_req_alu_op2(op2), .alu_req_alu_res(res)
    );

    always #5 clk = ~clk;

    // stand-in for the shared ALU datapath
    always_comb
        res = s_add ? op1 + op2 : s_sub ? op1 - op2 : s_xor ? op1 ^ op2 : s_or ? op1 | op2 :
              s_and ? op1 & op2 : s_lui ? op2 : 32'hDEAD0000 ^ op1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ops: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 lui, 6 nop
    function automatic logic [20:0] mk(input int op, input bit isel, input bit psel, input logic [2:0] f);
        logic [20:0] info = '0;
        int pos [7] = '{4, 5, 6, 10, 11, 14, 4};
        info[pos[op]] = 1'b1;
        info[17] = (op == 6);
        info[15] = isel;
        info[16] = psel;
        {info[18], info[19], info[20]} = f;
        return info;
    endfunction

    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a ^ b;
            3: return a | b;
            4: return a & b;
            5: return b;
            default: return 32'hDEAD0000 ^ a;
        endcase
    endfunction

    // one cycle: called at posedge+1, returns at next posedge+1
    task automatic step(input bit v, input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [2:0] f,
                        input bit isel, input bit psel, input bit ordy, input bit fl);
        logic [31:0] a, b;
        bit er;
        alu_i_valid = v; alu_i_rs1 = rs1; alu_i_rs2 = rs2; alu_i_imm = imm; alu_i_pc = pc;
        alu_i_info = mk(op, isel, psel, f);
        alu_i_info[3:0] = 4'($urandom);
        alu_o_ready = ordy; alu_i_flush = fl;
        #3;
        a = psel ? pc : rs1;
        b = isel ? imm : rs2;
        er = !fl && (q.size() < DEPTH || ordy);
        chk("i_ready", alu_i_ready, er);
        chk("op1", op1, a);
        chk("op2", op2, b);
        chk("add_sel", s_add, op == 0);
        @(posedge clk);
        if (fl) q.delete();
        else if (v && er) q.push_back({model(op, a, b), f});
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, 3'b0, 0, 0, ordy, 0);
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (rst_n && mon_en) begin
            chk("pend_cnt", alu_o_pend_cnt, q.size());
            chk("o_valid", alu_o_valid, q.size() != 0);
            if (alu_o_valid && alu_o_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("wdat", alu_o_wbck_wdat, e[34:3]);
                chk("flags", {alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi}, e[2:0]);
                chk("err", alu_o_wbck_err, |e[2:0]);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", alu_o_valid, 0);
        chk("rst_pend", alu_o_pend_cnt, 0);
        chk("rst_wdat", alu_o_wbck_wdat, 0);
        chk("rst_err", alu_o_wbck_err, 0);
        rst_n = 1;
        mon_en = 1;
        @(posedge clk); #1;
        // ADDI 5+3, held then popped
        step(1, 0, 5, 0, 3, 0, 3'b0, 1, 0, 0, 0);
        chk("addi_wdat", alu_o_wbck_wdat, 8);
        chk("addi_pend", alu_o_pend_cnt, 1);
        idle(0);
        idle(1);
        // NOP and AUIPC
        step(1, 6, 32'h1234, 0, 0, 0, 3'b0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 32'h1000, 32'h80000000, 3'b0, 1, 1, 1, 0);
        idle(1);
        idle(1);
        // backpressure: third issue refused until the head leaves
        step(1, 0, 10, 1, 0, 0, 3'b0, 0, 0, 0, 0);
        step(1, 1, 10, 2, 0, 0, 3'b0, 0, 0, 0, 0);
        step(1, 2, 10, 3, 0, 0, 3'b0, 0, 0, 0, 0);
        chk("full_pend", alu_o_pend_cnt, 2);
        step(1, 2, 10, 3, 0, 0, 3'b0, 0, 0, 1, 0);
        idle(1);
        idle(1);
        // commit flags
        step(1, 0, 1, 1, 0, 0, 3'b100, 0, 0, 1, 0);
        step(1, 0, 2, 2, 0, 0, 3'b010, 0, 0, 1, 0);
        step(1, 0, 3, 3, 0, 0, 3'b001, 0, 0, 1, 0);
        idle(1);
        idle(1);
        // pointer wrap with sustained throughput
        for (int k = 1; k <= 7; k++) step(1, 0, k, 0, 0, 0, 3'b0, 0, 0, 1, 0);
        idle(1);
        idle(1);
        // flush with two entries held
        step(1, 3, 7, 8, 0, 0, 3'b0, 0, 0, 0, 0);
        step(1, 4, 7, 8, 0, 0, 3'b0, 0, 0, 0, 0);
        step(1, 0, 7, 8, 0, 0, 3'b0, 0, 0, 0, 1);
        chk("flush_valid", alu_o_valid, 0);
        chk("flush_pend", alu_o_pend_cnt, 0);
        idle(0);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 7) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom, $urandom, $urandom,
                 $urandom, f, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        // asynchronous reset with entries held
        step(1, 0, 9, 9, 0, 0, 3'b101, 0, 0, 0, 0);
        step(1, 0, 4, 4, 0, 0, 3'b0, 0, 0, 0, 0);
        alu_i_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_valid", alu_o_valid, 0);
        chk("arst_pend", alu_o_pend_cnt, 0);
        chk("arst_wdat", alu_o_wbck_wdat, 0);
        chk("arst_err", alu_o_wbck_err, 0);
        chk("arst_ecall", alu_o_cmt_ecall, 0);
        q.delete();
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) step(1, 1, 100, k, 0, 0, 3'b0, 0, 0, 1, 0);
        repeat (DEPTH + 2) idle(1);
        chk("drain_pend", alu_o_pend_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
